set_mode_ctrl: RTL

SET_MODE_CTRL -- requirements
Module: set_mode_ctrl

---
 rtl/set_mode_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/set_mode_ctrl.sv
// set_mode_ctrl: push-button mode controller (RUN / SET_TIME / SET_ALARM) with debounced increment strobes.
// Optional hold-to-repeat of the increment strobes is enabled by defining SET_MODE_AUTO_REPEAT_EN.
module set_mode_ctrl #(
  parameter int unsigned DB_CYCLES      = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned RATE_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       switch,
  input  logic       push1,
  input  logic       push2,
  input  logic       push3,
  output logic [1:0] mode,
  output logic       setting,
  output logic       sel_alarm,
  output logic       inc_min,
  output logic       inc_hour
);

  localparam int unsigned NB   = 3;
  localparam int unsigned DB_W = $clog2(DB_CYCLES + 3);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
  // Two extra samples cover the synchronizer flops still holding their reset value.
  localparam logic [DB_W-1:0] ARM_LAST = DB_W'(DB_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    SET_TIME  = 2'b01,
    SET_ALARM = 2'b10
  } state_e;

  state_e          state_q, next_state;
  logic [NB-1:0]   push_raw_c, sync1_q, sync2_q, db_q, armed_q, press_q;
  logic [DB_W-1:0] db_cnt_q  [NB];
  logic [DB_W-1:0] arm_cnt_q [NB];
  logic [TO_W-1:0] idle_q;
  logic            in_set_c, timeout_c;
  logic [1:0]      strobe_c, rep_fire_c, inc_d_c;

  assign push_raw_c = {push3, push2, push1};
  assign in_set_c   = (state_q != RUN);
  assign mode       = state_q;

  // Two-flop synchronizers; reset to the released level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= push_raw_c;
      sync2_q <= sync1_q;
    end
  end

  // Debounce, press detection and post-reset arming (a button held through reset stays silent).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q    <= '1;
      armed_q <= '0;
      press_q <= '0;
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i]  <= '0;
        arm_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_cnt_q[i] <= '0;
          db_q[i]     <= sync2_q[i];
          press_q[i]  <= armed_q[i] & ~sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end

        if (!sync2_q[i]) begin
          arm_cnt_q[i] <= '0;
        end else if (arm_cnt_q[i] == ARM_LAST) begin
          armed_q[i] <= 1'b1;
        end else begin
          arm_cnt_q[i] <= arm_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Next-state logic; switch=0 in a set state overrides everything.
  always_comb begin
    next_state = state_q;
    timeout_c  = in_set_c && (idle_q == TO_LAST) && (press_q == '0);
    case (state_q)
      RUN:       if (press_q[0] && switch) next_state = SET_TIME;
      SET_TIME:  if (press_q[0])           next_state = SET_ALARM;
                 else if (timeout_c)       next_state = RUN;
      SET_ALARM: if (press_q[0] || timeout_c) next_state = RUN;
      default:   next_state = RUN;
    endcase
    if (in_set_c && !switch) next_state = RUN;
  end

  // A push1 event in the same cycle suppresses both increment strobes.
  always_comb begin
    strobe_c = '0;
    if (in_set_c && !press_q[0]) strobe_c = press_q[2:1];
  end

  assign inc_d_c = strobe_c | rep_fire_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      setting   <= 1'b0;
      sel_alarm <= 1'b0;
      inc_min   <= 1'b0;
      inc_hour  <= 1'b0;
      idle_q    <= '0;
    end else begin
      state_q   <= next_state;
      setting   <= (next_state != RUN);
      sel_alarm <= (next_state == SET_ALARM);
      inc_min   <= inc_d_c[0];
      inc_hour  <= inc_d_c[1];
      if (!in_set_c || (next_state != state_q) || (press_q != '0)) idle_q <= '0;
      else                                                         idle_q <= idle_q + TO_W'(1);
    end
  end

`ifdef SET_MODE_AUTO_REPEAT_EN
  localparam int unsigned RP_MAX = (HOLD_CYCLES > RATE_CYCLES) ? HOLD_CYCLES : RATE_CYCLES;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);
  localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYCLES - 1);
  localparam logic [RP_W-1:0] RATE_LAST = RP_W'(RATE_CYCLES - 1);

  logic [1:0]      rep_act_q, rep_rate_q;
  logic [RP_W-1:0] rep_cnt_q [2];
  logic            keep_c;

  // Repeat only while held, in a set state, with no state change pending.
  always_comb begin
    keep_c = in_set_c && (next_state == state_q);
    for (int i = 0; i < 2; i++) begin
      rep_fire_c[i] = rep_act_q[i] && keep_c && !db_q[i+1] &&
                      (rep_cnt_q[i] == (rep_rate_q[i] ? RATE_LAST : HOLD_LAST));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_act_q  <= '0;
      rep_rate_q <= '0;
      for (int i = 0; i < 2; i++) rep_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (strobe_c[i]) begin
          rep_act_q[i]  <= 1'b1;
          rep_rate_q[i] <= 1'b0;
          rep_cnt_q[i]  <= '0;
        end else if (!rep_act_q[i] || !keep_c || db_q[i+1]) begin
          rep_act_q[i]  <= 1'b0;
        end else if (rep_fire_c[i]) begin
          rep_rate_q[i] <= 1'b1;
          rep_cnt_q[i]  <= '0;
        end else begin
          rep_cnt_q[i]  <= rep_cnt_q[i] + RP_W'(1);
        end
      end
    end
  end
`else
  assign rep_fire_c = '0;
`endif

endmodule
